// File: rtl/cpu_reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// cpu_reset_seq_pkg
//   Shared board-level definitions for the 68040 reset sequencer: the
//   sequencer state encoding, default cycle counts at a 100 MHz system clock,
//   the rst_count saturation limit, and a small helper used to size the
//   sequencing timer.
// ---------------------------------------------------------------------------
package cpu_reset_seq_pkg;

  // Sequencer states, in the order a full reset walks through them.
  typedef enum logic [1:0] {
    POR_WAIT = 2'd0,
    ASSERT   = 2'd1,
    LEAD     = 2'd2,
    RUN      = 2'd3
  } rstState_t;

  // Default hold lengths at 100 MHz.
  localparam int DefaultPorCycles  = 25_000_000;
  localparam int DefaultRstCycles  = 1_000;
  localparam int DefaultPeriphLead = 100;

  // Width and ceiling of the accepted-button-reset counter.
  localparam int         RstCountW   = 8;
  localparam logic [7:0] RstCountMax = 8'd255;

  // Largest of three lengths; the timer must be able to hold the longest one.
  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/cpu_reset_seq.sv
// ---------------------------------------------------------------------------
// cpu_reset_seq
//   Turns the debounced reset-button strobe into board resets for the 68040
//   and its peripherals. Holds everything in reset after power-on, performs a
//   full reset on each new button press, releases peripherals PERIPH_LEAD
//   cycles before the CPU, and mirrors the CPU's RSTO output onto the
//   peripheral reset while the CPU is running (RESET instruction).
//
// Ports
//   i_clk        system clock (100 MHz)
//   i_rst        synchronous active-high FPGA reset
//   i_btn_press  debounced button level, same clock domain
//   i_cpu_rsto   68040 RSTO, active high, already synchronised
//   o_cpu_rst_n  68040 RSTI, active low
//   o_periph_rst peripheral reset, active high
//   o_busy       high whenever the sequencer is not in RUN
//   o_rst_count  accepted button resets, saturating at 255
// ---------------------------------------------------------------------------
module cpu_reset_seq
  import cpu_reset_seq_pkg::*;
#(
  parameter int POR_CYCLES  = DefaultPorCycles,
  parameter int RST_CYCLES  = DefaultRstCycles,
  parameter int PERIPH_LEAD = DefaultPeriphLead
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_btn_press,
  input  logic                 i_cpu_rsto,
  output logic                 o_cpu_rst_n,
  output logic                 o_periph_rst,
  output logic                 o_busy,
  output logic [RstCountW-1:0] o_rst_count
);

  localparam int TimerW = $clog2(maxOf3(POR_CYCLES, RST_CYCLES, PERIPH_LEAD) + 1);

  // The reset edge itself is not part of the power-on hold: the first edge
  // with rst low is the first counted cycle, so POR_WAIT leaves once the timer
  // has reached POR_CYCLES. States entered from another state start at zero
  // on their entry edge, so they leave when the timer reaches length-1.
  localparam logic [TimerW-1:0] PorLast    = TimerW'(POR_CYCLES);
  localparam logic [TimerW-1:0] AssertLast = TimerW'(RST_CYCLES - 1);
  localparam logic [TimerW-1:0] LeadLast   = TimerW'(PERIPH_LEAD - 1);
  localparam logic [TimerW-1:0] TimerOne   = TimerW'(1);

  rstState_t            r_state;
  rstState_t            w_nextState;
  logic [TimerW-1:0]    r_timer;
  logic [TimerW-1:0]    w_nextTimer;
  logic                 r_btnQ;
  logic                 w_btnEdge;
  logic                 w_accept;
  logic [RstCountW-1:0] r_rstCount;
  logic [RstCountW-1:0] w_nextCount;
  logic                 r_cpuRstN;
  logic                 r_periphRst;
  logic                 r_busy;
  logic                 w_nextCpuRstN;
  logic                 w_nextPeriphRst;
  logic                 w_nextBusy;

  // A held button must produce exactly one reset, so only the rising edge of
  // the strobe is acted on. Presses during the power-on hold are not accepted.
  assign w_btnEdge = i_btn_press & ~r_btnQ;
  assign w_accept  = w_btnEdge & (r_state != POR_WAIT);

  // State register together with the sequencing timer and the one-cycle
  // button history used for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= POR_WAIT;
      r_timer <= '0;
      r_btnQ  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_timer <= w_nextTimer;
      r_btnQ  <= i_btn_press;
    end
  end

  // Next-state logic. Any accepted press outside POR_WAIT restarts the full
  // reset from the top of ASSERT, which also covers a press that lands on the
  // same cycle as RSTO rising in RUN: the button takes priority.
  always_comb begin
    w_nextState = r_state;
    w_nextTimer = r_timer + TimerOne;
    case (r_state)
      POR_WAIT: begin
        if (r_timer == PorLast) begin
          w_nextState = LEAD;
          w_nextTimer = '0;
        end
      end
      ASSERT: begin
        if (w_btnEdge) begin
          w_nextState = ASSERT;
          w_nextTimer = '0;
        end else if (r_timer == AssertLast) begin
          w_nextState = LEAD;
          w_nextTimer = '0;
        end
      end
      LEAD: begin
        if (w_btnEdge) begin
          w_nextState = ASSERT;
          w_nextTimer = '0;
        end else if (r_timer == LeadLast) begin
          w_nextState = RUN;
          w_nextTimer = '0;
        end
      end
      RUN: begin
        w_nextTimer = '0;
        if (w_btnEdge) begin
          w_nextState = ASSERT;
        end
      end
      default: begin
        w_nextState = POR_WAIT;
        w_nextTimer = '0;
      end
    endcase
  end

  // Accepted presses are counted, holding at the ceiling rather than wrapping
  // so software can tell "many" from "few".
  always_comb begin
    w_nextCount = r_rstCount;
    if (w_accept && (r_rstCount != RstCountMax)) begin
      w_nextCount = r_rstCount + 8'd1;
    end
  end

  // Output decode from the state being entered, so the registered outputs
  // change on the same edge as the state. RSTO only drives the peripheral
  // reset when the sequencer was already in RUN and stays there; on the
  // LEAD-to-RUN edge and in every other state it is ignored.
  always_comb begin
    w_nextCpuRstN   = 1'b0;
    w_nextPeriphRst = 1'b1;
    w_nextBusy      = 1'b1;
    case (w_nextState)
      POR_WAIT, ASSERT: begin
        w_nextCpuRstN   = 1'b0;
        w_nextPeriphRst = 1'b1;
        w_nextBusy      = 1'b1;
      end
      LEAD: begin
        w_nextCpuRstN   = 1'b0;
        w_nextPeriphRst = 1'b0;
        w_nextBusy      = 1'b1;
      end
      RUN: begin
        w_nextCpuRstN   = 1'b1;
        w_nextPeriphRst = (r_state == RUN) & i_cpu_rsto;
        w_nextBusy      = 1'b0;
      end
      default: begin
        w_nextCpuRstN   = 1'b0;
        w_nextPeriphRst = 1'b1;
        w_nextBusy      = 1'b1;
      end
    endcase
  end

  // Output and counter registers; reset leaves the board held in reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cpuRstN   <= 1'b0;
      r_periphRst <= 1'b1;
      r_busy      <= 1'b1;
      r_rstCount  <= '0;
    end else begin
      r_cpuRstN   <= w_nextCpuRstN;
      r_periphRst <= w_nextPeriphRst;
      r_busy      <= w_nextBusy;
      r_rstCount  <= w_nextCount;
    end
  end

  assign o_cpu_rst_n  = r_cpuRstN;
  assign o_periph_rst = r_periphRst;
  assign o_busy       = r_busy;
  assign o_rst_count  = r_rstCount;

endmodule

// File: tb/tb_cpu_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_cpu_reset_seq
//   Directed bench for cpu_reset_seq with short cycle counts
//   (POR_CYCLES=20, RST_CYCLES=8, PERIPH_LEAD=3). Expected values are written
//   out by hand relative to edge numbers within each scenario.
// ---------------------------------------------------------------------------
module tb_cpu_reset_seq;

  localparam int PorCycles  = 20;
  localparam int RstCycles  = 8;
  localparam int PeriphLead = 3;

  logic       clk;
  logic       rst;
  logic       btnPress;
  logic       cpuRsto;
  logic       cpuRstN;
  logic       periphRst;
  logic       busy;
  logic [7:0] rstCount;

  int checksRun;
  int checksPassed;

  cpu_reset_seq #(
    .POR_CYCLES (PorCycles),
    .RST_CYCLES (RstCycles),
    .PERIPH_LEAD(PeriphLead)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_btn_press (btnPress),
    .i_cpu_rsto  (cpuRsto),
    .o_cpu_rst_n (cpuRstN),
    .o_periph_rst(periphRst),
    .o_busy      (busy),
    .o_rst_count (rstCount)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checksRun++;
    if (actual == expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs are set between edges so the next rising edge samples them.
  task automatic applyStimulus(input logic rstV, input logic btnV, input logic rstoV);
    rst      = rstV;
    btnPress = btnV;
    cpuRsto  = rstoV;
  endtask

  // Advance through one rising edge and settle just after it.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Power-on sequence from the first edge with rst low (edge 0). A short
  // button press during the hold must be ignored.
  task automatic runPorSequence(input string tag);
    for (int e = 0; e < 24; e++) begin
      applyStimulus(1'b0, (e >= 5 && e <= 7), 1'b0);
      stepClock();
      if (e == 19) begin
        checkOutput({tag, " periph_rst e19"}, periphRst, 1);
        checkOutput({tag, " cpu_rst_n e19"}, cpuRstN, 0);
      end
      if (e == 20) begin
        checkOutput({tag, " periph_rst e20"}, periphRst, 0);
        checkOutput({tag, " cpu_rst_n e20"}, cpuRstN, 0);
      end
      if (e == 22) begin
        checkOutput({tag, " cpu_rst_n e22"}, cpuRstN, 0);
        checkOutput({tag, " busy e22"}, busy, 1);
      end
      if (e == 23) begin
        checkOutput({tag, " cpu_rst_n e23"}, cpuRstN, 1);
        checkOutput({tag, " busy e23"}, busy, 0);
        checkOutput({tag, " periph_rst e23"}, periphRst, 0);
        checkOutput({tag, " count after POR press"}, rstCount, 0);
      end
    end
  endtask

  initial begin
    checksRun    = 0;
    checksPassed = 0;

    // Reset for two edges.
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepClock();
    stepClock();
    checkOutput("reset cpu_rst_n", cpuRstN, 0);
    checkOutput("reset periph_rst", periphRst, 1);
    checkOutput("reset busy", busy, 1);
    checkOutput("reset count", rstCount, 0);

    runPorSequence("por1");

    // Button held 50 cycles in RUN: one accepted edge, full sequence.
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      stepClock();
      if (i == 0) begin
        checkOutput("btn assert cpu_rst_n", cpuRstN, 0);
        checkOutput("btn assert periph_rst", periphRst, 1);
        checkOutput("btn assert busy", busy, 1);
        checkOutput("btn count", rstCount, 1);
      end
      if (i == 7) checkOutput("btn assert last periph", periphRst, 1);
      if (i == 8) begin
        checkOutput("btn lead periph", periphRst, 0);
        checkOutput("btn lead cpu", cpuRstN, 0);
      end
      if (i == 10) checkOutput("btn lead last cpu", cpuRstN, 0);
      if (i == 11) begin
        checkOutput("btn run cpu", cpuRstN, 1);
        checkOutput("btn run busy", busy, 0);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("btn held count", rstCount, 1);
    checkOutput("btn held still run", cpuRstN, 1);

    // Restart: second press 4 cycles into ASSERT extends it 8 cycles from
    // the second press.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, (k == 0 || k == 4), 1'b0);
      stepClock();
      if (k == 0) checkOutput("restart first count", rstCount, 2);
      if (k == 4) checkOutput("restart second count", rstCount, 3);
      if (k == 8) checkOutput("restart extended periph", periphRst, 1);
      if (k == 11) checkOutput("restart assert last periph", periphRst, 1);
      if (k == 12) begin
        checkOutput("restart lead periph", periphRst, 0);
        checkOutput("restart lead cpu", cpuRstN, 0);
      end
      if (k == 15) begin
        checkOutput("restart run cpu", cpuRstN, 1);
        checkOutput("restart run busy", busy, 0);
      end
    end

    // RSTO high for 5 sampled edges in RUN.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 1'b0, (k <= 4));
      stepClock();
      checkOutput($sformatf("rsto periph k%0d", k), periphRst, (k <= 4) ? 1 : 0);
      checkOutput($sformatf("rsto cpu k%0d", k), cpuRstN, 1);
      checkOutput($sformatf("rsto busy k%0d", k), busy, 0);
    end

    // Collision: button edge and RSTO rise together; RSTO then ignored.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, (k == 0), (k <= 9));
      stepClock();
      if (k == 0) begin
        checkOutput("coll cpu", cpuRstN, 0);
        checkOutput("coll periph", periphRst, 1);
        checkOutput("coll busy", busy, 1);
        checkOutput("coll count", rstCount, 4);
      end
      if (k == 7) checkOutput("coll assert last periph", periphRst, 1);
      if (k == 8) checkOutput("coll lead periph rsto", periphRst, 0);
      if (k == 9) checkOutput("coll lead periph rsto2", periphRst, 0);
      if (k == 10) checkOutput("coll lead last cpu", cpuRstN, 0);
      if (k == 11) begin
        checkOutput("coll run cpu", cpuRstN, 1);
        checkOutput("coll run busy", busy, 0);
        checkOutput("coll run periph", periphRst, 0);
      end
    end

    // Saturation: 260 presses on top of a count of 4.
    for (int p = 1; p <= 260; p++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      stepClock();
      if (p == 250) checkOutput("sat count 254", rstCount, 254);
      if (p == 251) checkOutput("sat count 255", rstCount, 255);
      applyStimulus(1'b0, 1'b0, 1'b0);
      stepClock();
    end
    checkOutput("sat count hold", rstCount, 255);

    // Last press entered ASSERT two edges ago; reach LEAD at press+8.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      stepClock();
    end
    checkOutput("pre-rst lead periph", periphRst, 0);
    checkOutput("pre-rst lead cpu", cpuRstN, 0);

    // Reset during LEAD.
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepClock();
    checkOutput("midrst cpu", cpuRstN, 0);
    checkOutput("midrst periph", periphRst, 1);
    checkOutput("midrst busy", busy, 1);
    checkOutput("midrst count", rstCount, 0);

    runPorSequence("por2");

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
